// File: rtl/usb_tx_scheduler.sv
// rtl/usb_tx_scheduler.sv - round-robin packet scheduler feeding a USB bit writer
// Grants one of four packet classes, then paces start/sync/payload/EOP strobes and an inter-packet gap.
module usb_tx_scheduler #(
   parameter int CLK_DIV    = 4,
   parameter int GAP_SHIFTS = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [23:0] tok_payload,
   input  logic [87:0] dat_payload,
   input  logic [7:0]  hs_payload,
   input  logic [23:0] spc_payload,
   output logic [87:0] wr_data,
   output logic        wr_ready,
   output logic [2:0]  wr_select,
   output logic        wr_shift,
   output logic [3:0]  ack,
   output logic [3:0]  done,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_t;

   localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);
   localparam logic [6:0] GAP_N   = 7'(GAP_SHIFTS);

   state_t      state_q;
   logic [7:0]  div_q, div_d;
   logic [6:0]  cnt_q;
   logic [6:0]  total_q;
   logic [1:0]  last_q;
   logic [87:0] data_q;
   logic [2:0]  sel_q;
   logic        ready_q;
   logic [3:0]  ack_q;
   logic [3:0]  done_q;
   logic        busy_q;

   logic        strobe;
   logic        gnt_valid;
   logic [1:0]  gnt_idx;
   logic [1:0]  idx;
   logic [87:0] pay_mux;
   logic [6:0]  len_mux;

   // Divider runs freely across LOAD/SEND/GAP so packet and gap strobes stay evenly spaced.
   always_comb begin
      strobe = (state_q != S_IDLE) && (div_q == DIV_MAX);
      div_d  = (state_q == S_IDLE || strobe) ? 8'd0 : div_q + 8'd1;
   end

   // Search starts one past the previous winner so every class gets a turn.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = last_q;
      idx       = last_q;
      for (int i = 1; i <= 4; i++) begin
         idx = last_q + 2'(i);
         if (!gnt_valid && req[idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = idx;
         end
      end
   end

   always_comb begin
      pay_mux = '0;
      len_mux = 7'd36;
      case (gnt_idx)
         2'd0: begin pay_mux = {64'd0, tok_payload}; len_mux = 7'd36;  end
         2'd1: begin pay_mux = dat_payload;          len_mux = 7'd100; end
         2'd2: begin pay_mux = {80'd0, hs_payload};  len_mux = 7'd20;  end
         default: begin pay_mux = {64'd0, spc_payload}; len_mux = 7'd36; end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         cnt_q   <= '0;
         total_q <= '0;
         last_q  <= 2'd3;
         data_q  <= '0;
         sel_q   <= '0;
         ready_q <= 1'b0;
         ack_q   <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         div_q  <= div_d;
         ack_q  <= '0;
         done_q <= '0;
         case (state_q)
            S_IDLE: begin
               if (gnt_valid) begin
                  state_q <= S_LOAD;
                  last_q  <= gnt_idx;
                  sel_q   <= {1'b0, gnt_idx};
                  data_q  <= pay_mux;
                  total_q <= len_mux;
                  cnt_q   <= '0;
                  ack_q   <= 4'b0001 << gnt_idx;
                  busy_q  <= 1'b1;
                  ready_q <= 1'b1;
               end
            end
            S_LOAD: begin
               if (strobe) begin
                  state_q <= S_SEND;
                  cnt_q   <= 7'd1;
                  ready_q <= 1'b0;
               end
            end
            S_SEND: begin
               if (strobe) begin
                  if (cnt_q + 7'd1 == total_q) begin
                     done_q <= 4'b0001 << sel_q[1:0];
                     cnt_q  <= '0;
                     if (GAP_N == 7'd0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                     end else begin
                        state_q <= S_GAP;
                     end
                  end else begin
                     cnt_q <= cnt_q + 7'd1;
                  end
               end
            end
            S_GAP: begin
               if (strobe) begin
                  if (cnt_q + 7'd1 == GAP_N) begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + 7'd1;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign wr_data   = data_q;
   assign wr_ready  = ready_q;
   assign wr_select = sel_q;
   assign wr_shift  = strobe;
   assign ack       = ack_q;
   assign done      = done_q;
   assign busy      = busy_q;

endmodule

// File: doc/usb_tx_scheduler.md
USB_TX_SCHEDULER -- requirements
Module: usb_tx_scheduler

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, clk cycles per shift strobe (legal 1..255).
REQ-002 SHALL have parameter GAP_SHIFTS, default 2, idle shift periods between packets (legal 0..15).
REQ-003 SHALL have port clk  in  1  single clock; all flops on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  in  4  request per packet class: [0] token, [1] data, [2] handshake, [3] special.
REQ-006 SHALL have port tok_payload  in  24  token packet bits, LSB sent first.
REQ-007 SHALL have port dat_payload  in  88  data packet bits, LSB sent first.
REQ-008 SHALL have port hs_payload  in  8  handshake packet bits, LSB sent first.
REQ-009 SHALL have port spc_payload  in  24  special packet bits, LSB sent first.
REQ-010 SHALL have port wr_data  out  88  payload to USB writer, zero-extended.
REQ-011 SHALL have port wr_ready  out  1  packet-start request to writer.
REQ-012 SHALL have port wr_select  out  3  packet class: 000 token, 001 data, 010 handshake, 011 special.
REQ-013 SHALL have port wr_shift  out  1  bit-period strobe to writer.
REQ-014 SHALL have port ack  out  4  one-hot, 1-cycle pulse: request granted, payload captured.
REQ-015 SHALL have port done  out  4  one-hot, 1-cycle pulse: granted packet fully shifted.
REQ-016 SHALL have port busy  out  1  high from grant until return to IDLE.

Function
REQ-017 SHALL implement states IDLE, LOAD, SEND, GAP.
REQ-018 In IDLE with any req bit high, SHALL grant round-robin starting at index (last_grant+1) mod 4, move to LOAD on the next edge, and capture payload, wr_select, and the class length N (token 24, data 88, handshake 8, special 24) on that edge.
REQ-019 ack bit of the granted class SHALL be high for exactly the first LOAD cycle; a requester SHALL hold req until ack; a req dropped before sampling is not granted.
REQ-020 Divider SHALL be 0 in IDLE and count 0..CLK_DIV-1 in LOAD/SEND/GAP; wr_shift SHALL be high exactly when divider = CLK_DIV-1; so the first strobe comes in the CLK_DIV-th LOAD cycle, with wr_shift constantly high while active for CLK_DIV=1.
REQ-021 wr_ready SHALL be high throughout LOAD; LOAD->SEND on the first wr_shift, wr_ready low from the next cycle.
REQ-022 Shift counter SHALL count all strobes of the packet including the LOAD strobe; total strobes per packet SHALL be N+12 (1 start, 8 sync, N payload, 3 EOP): 36/100/20/36.
REQ-023 On the strobe that brings the count to N+12, SHALL move SEND->GAP and pulse done for the granted class in the following cycle.
REQ-024 GAP SHALL last GAP_SHIFTS strobes, then go to IDLE; for GAP_SHIFTS=0, SHALL go directly SEND->IDLE.
REQ-025 busy SHALL be low in the first IDLE cycle; a new grant SHALL be possible on that IDLE cycle's edge.
REQ-026 wr_data and wr_select SHALL stay stable from LOAD until the next grant; payload input changes after ack SHALL have no effect.
REQ-027 req bits arriving while busy SHALL be held pending, without ack, until IDLE arbitration.
REQ-028 last_grant SHALL update only on grant.

Reset
REQ-029 On rst high, immediately and regardless of state: state IDLE, divider 0, shift counter 0, last_grant 3, wr_data 0, wr_ready 0, wr_select 000, wr_shift 0, ack 0, done 0, busy 0.
REQ-030 Reset mid-packet SHALL drop the packet with no done pulse; the first grant after release SHALL be token if requested.

Verification (CLK_DIV=4, GAP_SHIFTS=2 unless noted)
REQ-031 Handshake only, req[2]=1, hs_payload=8'hD2 -> ack=0100 one cycle; wr_select=010; wr_data=88'hD2; first wr_shift 4 cycles after ack; 20 strobes; done=0100; busy high 88 cycles.
REQ-032 Data only, dat_payload=88'hA5A5...A5 -> wr_data matches; wr_select=001; 100 strobes then done=0010.
REQ-033 req=1111 held from reset -> grant order token, data, handshake, special; one ack/done each, none overlapping.
REQ-034 rst pulse at strobe 50 of a data packet -> all outputs at reset values same cycle; no done=0010; re-requested token granted first.
REQ-035 req[1] raised during a handshake SEND -> no ack until IDLE; grant on first IDLE edge; data packet follows.
REQ-036 CLK_DIV=1, GAP_SHIFTS=0, token req -> wr_shift high every active cycle; done after 36 cycles of SEND plus LOAD; IDLE next.
